// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of the shared EX-stage add/sub ALU.
// Each transaction walks IDLE (grant/accept) -> EXEC (drive ALU) -> RESP (hold result until taken).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    req0Valid,
  input  logic                    req1Valid,
  input  logic [3:0]              req0Op,
  input  logic [3:0]              req1Op,
  input  logic signed [WIDTH-1:0] req0A,
  input  logic signed [WIDTH-1:0] req0B,
  input  logic signed [WIDTH-1:0] req1A,
  input  logic signed [WIDTH-1:0] req1B,
  output logic                    req0Ready,
  output logic                    req1Ready,
  output logic [3:0]              aluOperation,
  output logic signed [WIDTH-1:0] aluA,
  output logic signed [WIDTH-1:0] aluB,
  input  logic signed [WIDTH-1:0] aluResult,
  output logic                    resp0Valid,
  output logic                    resp1Valid,
  input  logic                    resp0Ready,
  input  logic                    resp1Ready,
  output logic signed [WIDTH-1:0] respData,
  output logic                    grantId
);

  localparam logic [3:0] OP_ADD = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic [3:0]              op_q, op_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic signed [WIDTH-1:0] b_q, b_d;
  logic signed [WIDTH-1:0] data_q, data_d;

  logic both_valid;
  logic any_valid;
  logic sel;
  logic accept;
  logic resp_taken;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    both_valid = req0Valid & req1Valid;
    any_valid  = req0Valid | req1Valid;
    sel        = both_valid ? ~last_grant_q : req1Valid;
    accept     = (state_q == IDLE) & any_valid & resetN;
    resp_taken = (state_q == RESP) & (grant_q ? resp1Ready : resp0Ready);
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction payload, grant bookkeeping and the captured result.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    if (accept) begin
      grant_d      = sel;
      last_grant_d = sel;
      op_d         = sel ? req1Op : req0Op;
      a_d          = sel ? req1A  : req0A;
      b_d          = sel ? req1B  : req0B;
    end
    if (state_q == EXEC) begin
      data_d = aluResult;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
    end
  end

  // Output logic; the ALU sees a harmless add of zeros whenever it is not owned.
  always_comb begin
    req0Ready    = accept & ~sel;
    req1Ready    = accept &  sel;
    aluOperation = OP_ADD;
    aluA         = '0;
    aluB         = '0;
    if (state_q == EXEC) begin
      aluOperation = op_q;
      aluA         = a_q;
      aluB         = b_q;
    end
    resp0Valid = (state_q == RESP) & ~grant_q;
    resp1Valid = (state_q == RESP) &  grant_q;
    respData   = data_q;
    grantId    = grant_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single transactions from a vector table, then
// contention, response backpressure and reset-abort sequences.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic                    clk;
  logic                    resetN;
  logic                    req0Valid, req1Valid;
  logic [3:0]              req0Op, req1Op;
  logic signed [WIDTH-1:0] req0A, req0B, req1A, req1B;
  logic                    req0Ready, req1Ready;
  logic [3:0]              aluOperation;
  logic signed [WIDTH-1:0] aluA, aluB, aluResult;
  logic                    resp0Valid, resp1Valid;
  logic                    resp0Ready, resp1Ready;
  logic signed [WIDTH-1:0] respData;
  logic                    grantId;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .resetN(resetN),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Op(req0Op), .req1Op(req1Op),
    .req0A(req0A), .req0B(req0B), .req1A(req1A), .req1B(req1B),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .aluOperation(aluOperation), .aluA(aluA), .aluB(aluB), .aluResult(aluResult),
    .resp0Valid(resp0Valid), .resp1Valid(resp1Valid),
    .resp0Ready(resp0Ready), .resp1Ready(resp1Ready),
    .respData(respData), .grantId(grantId)
  );

  // Stand-in for the combinational ALU.
  assign aluResult = (aluOperation == 4'b0110) ? aluA - aluB : aluA + aluB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_alu_idle(input string nm);
    chk({nm, "_aluop"}, {28'd0, aluOperation}, 32'h2);
    chk({nm, "_aluA"}, aluA, 32'd0);
    chk({nm, "_aluB"}, aluB, 32'd0);
  endtask

  // One isolated transaction; valid is presented in cycle c, response visible from edge c+2.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    resp0Ready = 1'b1;
    resp1Ready = 1'b1;
    if (v.id) begin
      req1Valid = 1'b1; req1Op = v.op; req1A = v.a; req1B = v.b;
    end else begin
      req0Valid = 1'b1; req0Op = v.op; req0A = v.a; req0B = v.b;
    end
    #1;
    chk({tag, "_ready"}, {31'd0, v.id ? req1Ready : req0Ready}, 32'd1);
    chk({tag, "_other_ready"}, {31'd0, v.id ? req0Ready : req1Ready}, 32'd0);
    step();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    chk({tag, "_exec_op"}, {28'd0, aluOperation}, {28'd0, v.op});
    chk({tag, "_exec_A"}, aluA, v.a);
    chk({tag, "_exec_B"}, aluB, v.b);
    chk({tag, "_grant"}, {31'd0, grantId}, {31'd0, v.id});
    chk({tag, "_exec_resp"}, {30'd0, resp1Valid, resp0Valid}, 32'd0);
    step();
    chk({tag, "_resp_valid"}, {30'd0, resp1Valid, resp0Valid}, v.id ? 32'd2 : 32'd1);
    chk({tag, "_data"}, respData, v.exp);
    chk_alu_idle({tag, "_resp"});
    step();
    chk({tag, "_after_resp"}, {30'd0, resp1Valid, resp0Valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{id: 1'b0, op: 4'b0010, a: 32'd5,          b: 32'd7,          exp: 32'd12};
    vecs[1] = '{id: 1'b1, op: 4'b0110, a: 32'd3,          b: 32'd10,         exp: 32'hFFFFFFF9};
    vecs[2] = '{id: 1'b0, op: 4'b0010, a: 32'h7FFFFFFF,   b: 32'd1,          exp: 32'h80000000};
    vecs[3] = '{id: 1'b1, op: 4'b0000, a: 32'd1,          b: 32'hFFFFFFFF,   exp: 32'd0};
    vecs[4] = '{id: 1'b0, op: 4'b0110, a: 32'd0,          b: 32'd1,          exp: 32'hFFFFFFFF};
    vecs[5] = '{id: 1'b1, op: 4'b0111, a: 32'd100,        b: 32'd28,         exp: 32'd128};

    resetN = 1'b0;
    req0Valid = 1'b1; req1Valid = 1'b0;
    req0Op = 4'b0110; req1Op = 4'b0110;
    req0A = 32'd9; req0B = 32'd9; req1A = 32'd0; req1B = 32'd0;
    resp0Ready = 1'b1; resp1Ready = 1'b1;

    // Reset state, with a request already waiting.
    repeat (2) step();
    chk("rst_ready0", {31'd0, req0Ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1Ready}, 32'd0);
    chk("rst_resp", {30'd0, resp1Valid, resp0Valid}, 32'd0);
    chk("rst_data", respData, 32'd0);
    chk("rst_grant", {31'd0, grantId}, 32'd0);
    chk_alu_idle("rst");
    req0Valid = 1'b0;
    resetN = 1'b1;

    // No requests: the ALU keeps its idle drive.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_alu_idle($sformatf("idle%0d", i));
      chk("idle_ready", {30'd0, req1Ready, req0Ready}, 32'd0);
    end

    // Contention: both valid for four back-to-back transactions.
    req0Valid = 1'b1; req0Op = 4'b0010; req0A = 32'd1;  req0B = 32'd2;
    req1Valid = 1'b1; req1Op = 4'b0110; req1A = 32'd10; req1B = 32'd4;
    for (int t = 0; t < 4; t++) begin
      logic exp_id;
      exp_id = t[0];
      #1;
      chk($sformatf("cont%0d_readys", t), {30'd0, req1Ready, req0Ready},
          exp_id ? 32'd2 : 32'd1);
      step();
      chk($sformatf("cont%0d_grant", t), {31'd0, grantId}, {31'd0, exp_id});
      chk($sformatf("cont%0d_exec_readys", t), {30'd0, req1Ready, req0Ready}, 32'd0);
      step();
      chk($sformatf("cont%0d_resp", t), {30'd0, resp1Valid, resp0Valid},
          exp_id ? 32'd2 : 32'd1);
      chk($sformatf("cont%0d_data", t), respData, exp_id ? 32'd6 : 32'd3);
      step();
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;

    // Isolated transactions from the table.
    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure on response 0 while requester 1 waits (last grant is 1, so req0 wins).
    resp0Ready = 1'b0; resp1Ready = 1'b1;
    req0Valid = 1'b1; req0Op = 4'b0010; req0A = 32'd20; req0B = 32'd22;
    req1Valid = 1'b1; req1Op = 4'b0110; req1A = 32'd50; req1B = 32'd9;
    #1;
    chk("bp_readys", {30'd0, req1Ready, req0Ready}, 32'd1);
    step();
    req0Valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_valid", i), {30'd0, resp1Valid, resp0Valid}, 32'd1);
      chk($sformatf("bp_hold%0d_data", i), respData, 32'd42);
      chk($sformatf("bp_hold%0d_ready1", i), {31'd0, req1Ready}, 32'd0);
      step();
    end
    resp0Ready = 1'b1;
    #1;
    chk("bp_release_valid", {31'd0, resp0Valid}, 32'd1);
    step();
    chk("bp_after_valid", {30'd0, resp1Valid, resp0Valid}, 32'd0);
    chk("bp_req1_ready", {31'd0, req1Ready}, 32'd1);
    step();
    req1Valid = 1'b0;
    chk("bp_req1_grant", {31'd0, grantId}, 32'd1);
    chk("bp_req1_op", {28'd0, aluOperation}, 32'h6);
    step();
    chk("bp_req1_resp", {30'd0, resp1Valid, resp0Valid}, 32'd2);
    chk("bp_req1_data", respData, 32'd41);
    step();

    // Reset during EXEC of a requester-0 transaction (which leaves last grant = 0).
    req0Valid = 1'b1; req0Op = 4'b0110; req0A = 32'd77; req0B = 32'd7;
    step();
    req0Valid = 1'b0;
    chk("abort_exec_op", {28'd0, aluOperation}, 32'h6);
    #1;
    resetN = 1'b0;
    #2;
    chk("abort_rst_resp", {30'd0, resp1Valid, resp0Valid}, 32'd0);
    chk("abort_rst_data", respData, 32'd0);
    chk_alu_idle("abort_rst");
    resetN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("abort_no_resp%0d", i), {30'd0, resp1Valid, resp0Valid}, 32'd0);
      chk_alu_idle($sformatf("abort_idle%0d", i));
    end
    req0Valid = 1'b1; req0Op = 4'b0010; req0A = 32'd4; req0B = 32'd4;
    req1Valid = 1'b1; req1Op = 4'b0010; req1A = 32'd8; req1B = 32'd8;
    #1;
    chk("abort_tie_readys", {30'd0, req1Ready, req0Ready}, 32'd1);
    step();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    chk("abort_tie_grant", {31'd0, grantId}, 32'd0);
    step();
    chk("abort_tie_data", respData, 32'd8);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
